// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, FSM encoding,
// request levels and the priority-encoder result type.
package int_ctrl_pkg;

    localparam int ID_W = 5;

    localparam logic [3:0] REG_PENDING  = 4'h0;
    localparam logic [3:0] REG_ENABLE   = 4'h4;
    localparam logic [3:0] REG_CLAIM    = 4'h8;
    localparam logic [3:0] REG_COMPLETE = 4'hC;

    localparam logic INT_ASSERT   = 1'b1;
    localparam logic INT_DEASSERT = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } int_state_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } prio_t;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder; id is index+1, 0 when nothing is set.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req,
    output prio_t              result
);

    always_comb begin
        result = '0;
        // Scan high to low so the lowest set index is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                result.valid = 1'b1;
                result.id    = ID_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge capture into PENDING, ENABLE mask, prioritised
// request to the core with a claim (int_ack_i) / complete (bus write) handshake.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    output logic               ack_o,
    output logic               int_o,
    output logic [ID_W-1:0]    int_id_o,
    input  logic               int_ack_i
);

    logic [NUM_SRC-1:0] src_q, pending, enable;
    logic [NUM_SRC-1:0] rise, clr, cur_mask;
    logic [ID_W-1:0]    cur_id;
    int_state_e         state;
    prio_t              win;
    logic               wr, wr_pending, wr_enable, wr_complete, claim;
    logic               unused_bits;

    assign unused_bits = ^{addr_i[31:4], data_i};

    assign wr          = req_i & we_i;
    assign wr_pending  = wr && (addr_i[3:0] == REG_PENDING);
    assign wr_enable   = wr && (addr_i[3:0] == REG_ENABLE);
    assign wr_complete = wr && (addr_i[3:0] == REG_COMPLETE);
    assign claim       = (state == ST_REQ) && int_ack_i;

    assign rise     = src_i & ~src_q;
    // cur_id of 0 shifts the one out entirely, giving an empty mask.
    assign cur_mask = NUM_SRC'(1) << (cur_id - ID_W'(1));

    always_comb begin
        clr = '0;
        if (wr_pending) clr = clr | data_i[NUM_SRC-1:0];
        if (claim)      clr = clr | cur_mask;
    end

    int_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
        .req    (pending & enable),
        .result (win)
    );

    always_comb begin
        case (addr_i[3:0])
            REG_PENDING: data_o = 32'(pending);
            REG_ENABLE:  data_o = 32'(enable);
            REG_CLAIM:   data_o = {{(32-ID_W){1'b0}}, cur_id};
            default:     data_o = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q   <= '0;
            pending <= '0;
            enable  <= '0;
            ack_o   <= 1'b0;
        end else begin
            src_q   <= src_i;
            // New edges win over any clear landing in the same cycle.
            pending <= (pending & ~clr) | rise;
            if (wr_enable) enable <= data_i[NUM_SRC-1:0];
            ack_o   <= req_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cur_id   <= '0;
            int_o    <= INT_DEASSERT;
            int_id_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    int_o    <= INT_DEASSERT;
                    int_id_o <= '0;
                    if (win.valid) begin
                        state    <= ST_REQ;
                        cur_id   <= win.id;
                        int_o    <= INT_ASSERT;
                        int_id_o <= win.id;
                    end
                end
                ST_REQ: begin
                    if (int_ack_i) begin
                        state <= ST_SVC;
                        int_o <= INT_DEASSERT;
                    end else if ((enable & cur_mask) == '0 || (pending & cur_mask) == '0) begin
                        // Source masked or cleared by software before the core took it.
                        state    <= ST_IDLE;
                        int_o    <= INT_DEASSERT;
                        int_id_o <= '0;
                    end
                end
                ST_SVC: begin
                    if (wr_complete && data_i[ID_W-1:0] == cur_id) begin
                        state    <= ST_IDLE;
                        int_id_o <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    int_o    <= INT_DEASSERT;
                    int_id_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: bus reads and interrupt requests are
// checked against expectations queued when the stimulus is driven.
module tb_int_ctrl;

    localparam int NUM_SRC = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_SRC-1:0] src_i = '0;
    logic               req_i = 1'b0;
    logic               we_i = 1'b0;
    logic [31:0]        addr_i = '0;
    logic [31:0]        data_i = '0;
    logic [31:0]        data_o;
    logic               ack_o;
    logic               int_o;
    logic [4:0]         int_id_o;
    logic               int_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_q[$];
    logic [4:0]  id_q[$];

    int_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_i     (src_i),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .ack_o     (ack_o),
        .int_o     (int_o),
        .int_id_o  (int_id_o),
        .int_ack_i (int_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'(a); data_i = d;
        tick();
        chk("wr_ack", 32'(ack_o), 32'd1);
        req_i = 1'b0; we_i = 1'b0; data_i = '0;
    endtask

    task automatic bus_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] e;
        rd_q.push_back(exp);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'(a);
        #1;
        e = rd_q.pop_front();
        chk(tag, data_o, e);
        tick();
        chk("rd_ack", 32'(ack_o), 32'd1);
        req_i = 1'b0;
    endtask

    // Wait for int_o, then compare latency and the queued expected ID.
    task automatic wait_req(input string tag, input int exp_lat);
        int lat = 0;
        logic [4:0] e;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (int_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            chk({tag, "_timeout"}, 32'(int_o), 32'd1);
            if (id_q.size() != 0) void'(id_q.pop_front());
        end else begin
            chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
            if (id_q.size() == 0) chk({tag, "_noexp"}, 32'(int_id_o), 32'h1f);
            else begin
                e = id_q.pop_front();
                chk({tag, "_id"}, 32'(int_id_o), 32'(e));
            end
        end
    endtask

    task automatic core_ack();
        int_ack_i = 1'b1;
        tick();
        int_ack_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_int_o", 32'(int_o), 32'd0);
        chk("rst_id", 32'(int_id_o), 32'd0);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        rst = 1'b0;
        tick();

        // Single source: latency, claim, complete
        bus_wr(4'h4, 32'h01);
        src_i = 8'h01; id_q.push_back(5'd1);
        wait_req("t1", 2);
        src_i = '0;
        bus_rd("t1_claim", 4'h8, 32'd1);
        bus_rd("t1_pend", 4'h0, 32'h01);
        core_ack();
        chk("t1_int_off", 32'(int_o), 32'd0);
        chk("t1_svc_id", 32'(int_id_o), 32'd1);
        bus_rd("t1_pend_clr", 4'h0, 32'h00);
        bus_wr(4'hC, 32'd1);
        chk("t1_idle_id", 32'(int_id_o), 32'd0);

        // Two simultaneous edges: lowest index first
        bus_wr(4'h4, 32'hFF);
        bus_rd("t2_en", 4'h4, 32'hFF);
        src_i = 8'h24; id_q.push_back(5'd3);
        wait_req("t2a", 2);
        src_i = '0;
        core_ack();
        bus_rd("t2_pend", 4'h0, 32'h20);
        bus_wr(4'hC, 32'd3);
        id_q.push_back(5'd6);
        wait_req("t2b", 1);
        core_ack();
        bus_wr(4'hC, 32'd6);

        // Mismatched COMPLETE is ignored
        src_i = 8'h04; id_q.push_back(5'd3);
        wait_req("t3", 2);
        src_i = '0;
        core_ack();
        bus_wr(4'hC, 32'd4);
        tick();
        chk("t3_stay_id", 32'(int_id_o), 32'd3);
        chk("t3_stay_int", 32'(int_o), 32'd0);
        bus_rd("t3_claim", 4'h8, 32'd3);
        bus_wr(4'hC, 32'd3);
        chk("t3_idle_id", 32'(int_id_o), 32'd0);

        // Masking while requested withdraws the request, pending stays
        bus_wr(4'h4, 32'h01);
        src_i = 8'h01; id_q.push_back(5'd1);
        wait_req("t4", 2);
        src_i = '0;
        bus_wr(4'h4, 32'h00);
        tick();
        chk("t4_withdrawn", 32'(int_o), 32'd0);
        chk("t4_withdrawn_id", 32'(int_id_o), 32'd0);
        bus_rd("t4_pend", 4'h0, 32'h01);
        bus_wr(4'h4, 32'h01);
        id_q.push_back(5'd1);
        wait_req("t4_reen", 1);
        core_ack();
        bus_wr(4'hC, 32'd1);

        // Edge in the same cycle as the claim of the same source
        bus_wr(4'h4, 32'h03);
        src_i = 8'h02; id_q.push_back(5'd2);
        wait_req("t5", 2);
        src_i = '0;
        tick();
        src_i = 8'h02; int_ack_i = 1'b1;
        tick();
        int_ack_i = 1'b0; src_i = '0;
        chk("t5_svc_int", 32'(int_o), 32'd0);
        bus_rd("t5_pend", 4'h0, 32'h02);
        bus_wr(4'hC, 32'd2);
        id_q.push_back(5'd2);
        wait_req("t5_again", 1);
        core_ack();
        bus_wr(4'h0, 32'h02);
        bus_rd("t5_w1c", 4'h0, 32'h00);
        bus_wr(4'hC, 32'd2);

        // Asynchronous reset while in service
        bus_wr(4'h4, 32'h01);
        src_i = 8'h01; id_q.push_back(5'd1);
        wait_req("t6", 2);
        src_i = '0;
        core_ack();
        addr_i = 32'h8; req_i = 1'b1;
        tick();
        chk("t6_pre_ack", 32'(ack_o), 32'd1);
        chk("t6_pre_id", 32'(int_id_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_ack", 32'(ack_o), 32'd0);
        chk("t6_rst_int", 32'(int_o), 32'd0);
        chk("t6_rst_id", 32'(int_id_o), 32'd0);
        chk("t6_rst_data", data_o, 32'd0);
        req_i = 1'b0;
        tick();
        #2 rst = 1'b0;
        tick();
        bus_rd("t6_pend", 4'h0, 32'd0);
        bus_rd("t6_en", 4'h4, 32'd0);
        bus_rd("t6_claim", 4'h8, 32'd0);
        req_i = 1'b1; addr_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_b2b_ack", 32'(ack_o), 32'd1);
        end
        req_i = 1'b0;
        tick();
        chk("t6_ack_drop", 32'(ack_o), 32'd0);
        chk("t6_idle_int", 32'(int_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
